truth_table_sweeper: RTL and testbench

Self-test sequencer for a 3-input, 1-output combinational block with ports x1, x2, x3 and f. On a start request it drives all 8 input vectors in ascending binary order, holds each for a programmable settle time, and samples f at the end of each hold. It assembles the 8-bit truth table and compares it against an expected signature. It sits between a test-control host and the combinational block under test.

---
 rtl/truth_table_sweeper.sv | 129 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Self-test sequencer: walks a 3-input combinational block through all 8 input
// vectors, samples f after a programmable hold and checks the table against a golden value.
module truth_table_sweeper #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [7:0]  EXPECTED    = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] cap_q, cap_d;
    logic [2:0] x_q, x_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] table_q, table_d;

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        cap_d      = cap_q;
        table_d    = table_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_APPLY;
                    idx_d      = 3'd0;
                    hold_cnt_d = 8'd0;
                    cap_d      = 8'h00;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    // A cancelled sweep leaves the published result untouched.
                    state_d    = ST_IDLE;
                    idx_d      = 3'd0;
                    hold_cnt_d = 8'd0;
                    cap_d      = 8'h00;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    cap_d[idx_q] = f;
                    hold_cnt_d   = 8'd0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_DONE;
                        table_d = cap_d;
                        pass_d  = (cap_d == EXPECTED);
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d    = ST_IDLE;
                idx_d      = 3'd0;
                hold_cnt_d = 8'd0;
                cap_d      = 8'h00;
            end
        endcase
        busy_d = (state_d == ST_APPLY);
        done_d = (state_d == ST_DONE);
        if (busy_d) begin
            x_d = idx_d;
        end else begin
            x_d = 3'b000;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            hold_cnt_q <= 8'd0;
            cap_q      <= 8'h00;
            x_q        <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            table_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            cap_q      <= cap_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            table_q    <= table_d;
        end
    end

    assign x1        = x_q[2];
    assign x2        = x_q[1];
    assign x3        = x_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (hold 2 and hold 1) against a
// cycle-count reference model, plus hand-computed sweep results.
module tb_truth_table_sweeper;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] ftab [2];

    logic [2:0] x0, x1v;
    logic       f0, f1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] table0, table1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: t = 0 idle, 1..8H sweep cycle, 8H+1 done cycle.
    int         m_t     [2] = '{0, 0};
    logic [7:0] m_cap   [2] = '{8'h00, 8'h00};
    logic [7:0] m_table [2] = '{8'h00, 8'h00};
    logic       m_pass  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    assign f0 = ftab[0][x0];
    assign f1 = ftab[1][x1v];

    truth_table_sweeper #(.HOLD_CYCLES(2), .EXPECTED(8'hE8)) u_dut_h2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f0),
        .x1(x0[2]), .x2(x0[1]), .x3(x0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .table_out(table0)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(8'hE8)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f1),
        .x1(x1v[2]), .x2(x1v[1]), .x3(x1v[0]),
        .busy(busy1), .done(done1), .pass(pass1), .table_out(table1)
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model advanced on every clock edge, cleared asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i]     <= 0;
                m_cap[i]   <= 8'h00;
                m_table[i] <= 8'h00;
                m_pass[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int h, t;
                logic [7:0] cap;
                h   = hold_of(i);
                t   = m_t[i];
                cap = m_cap[i];
                if (t == 0) begin
                    if (start && !abort) begin
                        t   = 1;
                        cap = 8'h00;
                    end
                end else if (t <= 8 * h) begin
                    if (abort) begin
                        t = 0;
                    end else begin
                        if (t % h == 0) cap[t / h - 1] = ftab[i][(t - 1) / h];
                        t = t + 1;
                        if (t == 8 * h + 1) begin
                            m_table[i] <= cap;
                            m_pass[i]  <= (cap == 8'hE8);
                        end
                    end
                end else begin
                    t = 0;
                end
                m_t[i]   <= t;
                m_cap[i] <= cap;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int h, t;
            logic       eb, ed;
            logic [2:0] ex;
            logic [13:0] exp_v, act_v;
            h  = hold_of(i);
            t  = m_t[i];
            eb = (t >= 1) && (t <= 8 * h);
            ed = (t == 8 * h + 1);
            ex = eb ? 3'((t - 1) / h) : 3'b000;
            exp_v = {ex, eb, ed, m_pass[i], m_table[i]};
            if (i == 0) act_v = {x0, busy0, done0, pass0, table0};
            else        act_v = {x1v, busy1, done1, pass1, table1};
            check($sformatf("model_h%0d {x,busy,done,pass,table}", h), 32'(act_v), 32'(exp_v));
        end
    end

    // Start a sweep at the next edge and report the cycle each instance shows done.
    task automatic sweep(input bit hold_start, input int ncyc, output int d0, output int d1,
                         output logic b18, output logic b19);
        d0 = -1; d1 = -1; b18 = 1'bx; b19 = 1'bx;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !hold_start) start = 1'b0;
            if (done0 && d0 < 0) d0 = c;
            if (done1 && d1 < 0) d1 = c;
            if (c == 18) b18 = busy0;
            if (c == 19) b19 = busy0;
        end
        start = 1'b0;
    endtask

    initial begin
        int d0, d1;
        logic b18, b19;
        logic done_seen;
        ftab[0] = 8'hE8;   // majority
        ftab[1] = 8'h96;   // odd parity

        // Reset held with start toggling.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = ~start;
        end
        #1;
        check("reset_hold outputs", 32'({x0, busy0, done0, pass0, table0}), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Nominal sweep (hold 2, majority) and mismatch sweep (hold 1, parity) together.
        sweep(1'b0, 24, d0, d1, b18, b19);
        check("nominal done cycle", 32'(d0), 32'd17);
        check("nominal table", 32'(table0), 32'hE8);
        check("nominal pass", 32'(pass0), 32'd1);
        check("mismatch done cycle", 32'(d1), 32'd9);
        check("mismatch table", 32'(table1), 32'h96);
        check("mismatch pass", 32'(pass1), 32'd0);

        // Abort raised in cycle 5.
        @(negedge clk);
        start = 1'b1;
        done_seen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == 5) abort = 1'b1;
            if (c == 6) begin
                abort = 1'b0;
                check("abort busy", 32'(busy0), 32'd0);
                check("abort x", 32'(x0), 32'd0);
            end
            if (done0 || done1) done_seen = 1'b1;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        check("abort keeps table", 32'(table0), 32'hE8);
        check("abort keeps pass", 32'(pass0), 32'd1);

        // start and abort together in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort idle", 32'(busy0), 32'd0);

        // start held high: back-to-back sweeps.
        sweep(1'b1, 20, d0, d1, b18, b19);
        check("held done cycle", 32'(d0), 32'd17);
        check("held idle cycle 18", 32'(b18), 32'd0);
        check("held restart cycle 19", 32'(b19), 32'd1);
        repeat (40) @(negedge clk);

        // Reset in cycle 9 of a hold-2 sweep, between edges.
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            if (c == 1) begin
                #1;
                start = 1'b0;
            end
        end
        #1;
        check("pre-reset busy", 32'(busy0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset h2 outputs", 32'({x0, busy0, done0, pass0, table0}), 32'd0);
        check("async reset h1 outputs", 32'({x1v, busy1, done1, pass1, table1}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep(1'b0, 24, d0, d1, b18, b19);
        check("post-reset done cycle", 32'(d0), 32'd17);
        check("post-reset table", 32'(table0), 32'hE8);
        check("post-reset pass", 32'(pass0), 32'd1);
        check("post-reset h1 table", 32'(table1), 32'h96);

        // Randomized traffic: requests, aborts, changing blocks, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) ftab[0] = 8'($urandom);
            if ($urandom_range(0, 31) == 0) ftab[1] = 8'($urandom);
            if ($urandom_range(0, 63) == 0) ftab[$urandom_range(0, 1)] = 8'hE8;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
